// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: FSM state encoding and bus-mode constants used by the
// initiator and the slave blocks it drives.
package spi_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic SPI_CPOL  = 1'b0;
    localparam logic SPI_CPHA  = 1'b0;
    localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_clk_divider.sv
// Phase-tick generator: tick is high on the last clk cycle of every CLK_DIV-cycle
// phase. restart holds the count at zero so each phase starts aligned.
module spi_clk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: frames a WIDTH-bit transfer with cs_n, shifts tx_data out
// on mosi and collects miso into rx_data, reporting completion with rx_valid.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             spi_clk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int BW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             restart;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] w, input logic b);
        return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
    endfunction

    // The divider only runs in the timed phases, so every phase starts from zero.
    assign restart = (state == S_IDLE) || (state == S_DONE);

    spi_clk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            spi_clk  <= SPI_CPOL;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            ready    <= 1'b1;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_shift <= tx_data;
                        cs_n     <= 1'b0;
                        mosi     <= out_bit(tx_data);
                        ready    <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= S_LEAD;
                    end else begin
                        cs_n <= 1'b1;
                    end
                end
                S_LEAD: begin
                    if (tick) begin
                        spi_clk <= ~SPI_CPOL;
                        state   <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // Sample at the end of the high phase to give the slave full setup.
                    if (tick) begin
                        rx_shift <= shift_rx(rx_shift, miso);
                        tx_shift <= shift_tx(tx_shift);
                        mosi     <= out_bit(shift_tx(tx_shift));
                        bit_cnt  <= bit_cnt + 1'b1;
                        spi_clk  <= SPI_CPOL;
                        state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (tick) begin
                        if (bit_cnt == BW'(WIDTH)) begin
                            cs_n     <= 1'b1;
                            mosi     <= 1'b0;
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            spi_clk <= ~SPI_CPOL;
                            state   <= S_HIGH;
                        end
                    end
                end
                S_DONE: begin
                    // A pending start re-selects the slave now, so back-to-back
                    // frames are separated by the DONE cycle alone.
                    cs_n  <= ~start;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 2, 1, 5) share stimulus; a
// cycle-accurate behavioural model of the SPI frame checks every output each cycle.
module tb_spi_master;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] tx_data;
    logic [W-1:0] sl_word;

    logic         spi_clk_a [3];
    logic         cs_n_a    [3];
    logic         mosi_a    [3];
    logic         miso_a    [3];
    logic         ready_a   [3];
    logic         rx_valid_a[3];
    logic [W-1:0] rx_data_a [3];

    int n_chk  = 0;
    int n_fail = 0;
    bit pin_en = 0;
    bit b2b    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        int falls = 0;

        spi_master #(.WIDTH(W), .CLK_DIV(D)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .tx_data (tx_data),
            .ready   (ready_a[g]),
            .rx_data (rx_data_a[g]),
            .rx_valid(rx_valid_a[g]),
            .spi_clk (spi_clk_a[g]),
            .cs_n    (cs_n_a[g]),
            .mosi    (mosi_a[g]),
            .miso    (miso_a[g])
        );

        // Mode-0 slave: first bit valid at select, next bit after each spi_clk fall.
        always @(negedge spi_clk_a[g] or posedge cs_n_a[g]) begin
            if (cs_n_a[g]) falls = 0;
            else           falls = falls + 1;
        end
        assign miso_a[g] = (!cs_n_a[g] && falls < W) ? sl_word[W-1-falls] : 1'b0;
    end

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction
    function automatic int lat_lit(input int i);
        return (i == 0) ? 35 : (i == 1) ? 18 : 86;
    endfunction
    function automatic int per_lit(input int i);
        return (i == 0) ? 4 : (i == 1) ? 2 : 10;
    endfunction
    function automatic int gap_lit(input int i);
        return (i == 0) ? 36 : (i == 1) ? 19 : 87;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Model state, one slot per instance
    int           abs_cyc = 0;
    bit           busy[3], pend[3], post_done[3], start_done[3], rv_seen[3];
    int           cyc[3], rises[3], last_rise[3], last_rv[3], hi_run[3];
    logic [W-1:0] m_tx[3], m_rx[3], pend_tx[3], pend_rx[3], last_rx[3], mosi_cap[3];
    logic         prev_sc[3], prev_cs[3];

    always @(negedge clk) begin
        abs_cyc++;
        for (int i = 0; i < 3; i++) begin
            int d, t, n, p, b;
            logic e_sc, e_cs, e_mo, e_rdy, e_rv, was_busy;
            logic [W-1:0] e_rx;
            d = div_of(i);
            t = (2 * W + 1) * d;
            e_sc = 1'b0; e_mo = 1'b0; e_rv = 1'b0; e_cs = 1'b1; e_rdy = 1'b1; e_rx = '0;
            if (rst) begin
                busy[i] = 0; pend[i] = 0; post_done[i] = 0; last_rx[i] = '0;
            end else begin
                if (pend[i]) begin
                    busy[i] = 1; cyc[i] = 0; m_tx[i] = pend_tx[i]; m_rx[i] = pend_rx[i];
                    rises[i] = 0; mosi_cap[i] = '0;
                end
                pend[i] = 0;
                if (busy[i]) cyc[i]++;
                n = cyc[i];
                e_rx = last_rx[i];
                if (!busy[i]) begin
                    e_cs = post_done[i] ? !start_done[i] : 1'b1;
                end else begin
                    e_rdy = 1'b0;
                    e_cs  = 1'b0;
                    if (n <= d) begin
                        e_mo = m_tx[i][W-1];
                    end else if (n <= t) begin
                        // Phase p alternates high/low; bit k is on the wire from the
                        // low phase before high phase k until the next low phase.
                        p = (n - 1 - d) / d;
                        e_sc = (p % 2 == 0);
                        b = W - 1 - (p + 1) / 2;
                        e_mo = (b >= 0) ? m_tx[i][b] : 1'b0;
                    end else begin
                        e_cs = 1'b1; e_rv = 1'b1; e_rx = m_rx[i];
                    end
                end
                post_done[i] = 0;
                was_busy = busy[i];
                if (busy[i] && n == t + 1) begin
                    busy[i] = 0; post_done[i] = 1; start_done[i] = start; last_rx[i] = m_rx[i];
                end
                if (!was_busy && start) begin
                    pend[i] = 1; pend_tx[i] = tx_data; pend_rx[i] = sl_word;
                end
            end
            chk("spi_clk",  i, 32'(spi_clk_a[i]),  32'(e_sc));
            chk("cs_n",     i, 32'(cs_n_a[i]),     32'(e_cs));
            chk("mosi",     i, 32'(mosi_a[i]),     32'(e_mo));
            chk("ready",    i, 32'(ready_a[i]),    32'(e_rdy));
            chk("rx_valid", i, 32'(rx_valid_a[i]), 32'(e_rv));
            chk("rx_data",  i, 32'(rx_data_a[i]),  32'(e_rx));

            if (!rst) begin
                if (spi_clk_a[i] && !prev_sc[i]) begin
                    rises[i]++;
                    mosi_cap[i] = {mosi_cap[i][W-2:0], mosi_a[i]};
                    if (rises[i] > 1) chk("sclk_period", i, 32'(abs_cyc - last_rise[i]), 32'(per_lit(i)));
                    last_rise[i] = abs_cyc;
                end
                if (rx_valid_a[i]) begin
                    if (pin_en) begin
                        chk("pin_latency", i, 32'(cyc[i]), 32'(lat_lit(i)));
                        chk("pin_rises",   i, 32'(rises[i]), 32'd8);
                        chk("pin_mosi",    i, 32'(mosi_cap[i]), 32'h A5);
                        chk("pin_rx",      i, 32'(rx_data_a[i]), 32'h 3C);
                    end
                    if (b2b && rv_seen[i]) chk("rv_gap", i, 32'(abs_cyc - last_rv[i]), 32'(gap_lit(i)));
                    rv_seen[i] = b2b;
                    last_rv[i] = abs_cyc;
                end
                if (!b2b) rv_seen[i] = 0;
                if (b2b && !cs_n_a[i] && prev_cs[i] && rv_seen[i]) chk("cs_hi_cycles", i, 32'(hi_run[i]), 32'd1);
                hi_run[i] = cs_n_a[i] ? hi_run[i] + 1 : 0;
            end
            prev_sc[i] = spi_clk_a[i];
            prev_cs[i] = cs_n_a[i];
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_all_ready();
        int c = 0;
        while (!(ready_a[0] && ready_a[1] && ready_a[2]) && c < 400) begin
            tick(1);
            c++;
        end
        if (!(ready_a[0] && ready_a[1] && ready_a[2])) begin
            $display("FAIL wait_ready: ready not reached within 400 cycles");
            $fatal(1, "timeout");
        end
    endtask

    task automatic do_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw);
        wait_all_ready();
        tx_data = tx;
        sl_word = sw;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    task automatic wait_rises0(input int k);
        int seen = 0;
        logic last = spi_clk_a[0];
        for (int c = 0; c < 2000 && seen < k; c++) begin
            tick(1);
            if (spi_clk_a[0] && !last) seen++;
            last = spi_clk_a[0];
        end
        if (seen < k) begin
            $display("FAIL wait_rises: saw %0d rises, needed %0d", seen, k);
            $fatal(1, "timeout");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; tx_data = '0; sl_word = '0;
        tick(3);
        rst = 1'b0;
        tick(3);

        // Basic transfer on all three dividers, pinned to literal values
        pin_en = 1;
        do_xfer(8'hA5, 8'h3C);
        wait_all_ready();

        // Start pulses and tx_data churn while busy are ignored
        do_xfer(8'hA5, 8'h3C);
        tick(10);
        tx_data = 8'h00; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_all_ready();
        pin_en = 0;
        tick(2);

        // Reset while idle clears rx_data
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);

        // Back-to-back with start held
        b2b = 1;
        sl_word = 8'($urandom);
        tx_data = 8'hFF; start = 1'b1;
        tick(1);
        tx_data = 8'h00;
        tick(190);
        start = 1'b0;
        wait_all_ready();
        tick(1);
        b2b = 0;
        tick(2);

        // Abort after the third spi_clk rise, then a clean transfer
        do_xfer(8'($urandom), 8'($urandom));
        wait_rises0(3);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        do_xfer(8'h81, 8'($urandom));
        wait_all_ready();

        // Randomized transfers with ignored start pulses while busy
        for (int r = 0; r < 20; r++) begin
            do_xfer(8'($urandom), 8'($urandom));
            tick($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 1) begin
                tx_data = 8'($urandom); start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            wait_all_ready();
            tick($urandom_range(0, 3));
        end

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
